// File: rtl/led_matrix_pkg.sv
// Shared helpers for the LED matrix driver: width calc, column select, data slicing.
// Dimming is compiled in only when LED_MATRIX_PWM_DIM_EN is defined (see led_matrix_pwm).
package led_matrix_pkg;

   localparam int unsigned MAX_COLS = 64;

   typedef enum logic [1:0] {
      PH_BLANK,
      PH_ON,
      PH_OFF
   } slot_phase_e;

   function automatic int unsigned clog2w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic logic [MAX_COLS-1:0] col_onecold(input int unsigned c);
      return ~(MAX_COLS'(1) << c);
   endfunction

   // Column 0 occupies the most significant ROWS bits of the frame word.
   function automatic int unsigned slice_msb(input int unsigned c, input int unsigned rows,
                                             input int unsigned cols);
      return (cols - c) * rows - 1;
   endfunction

endpackage

// File: rtl/led_matrix_scan.sv
// Column scan sequencer: slot timer, column counter, frame boundary and frame_tick.
module led_matrix_scan
   import led_matrix_pkg::*;
#(
   parameter int unsigned COLS      = 4,
   parameter int unsigned COL_TICKS = 50_000
) (
   input  logic                           clk,
   input  logic                           rst,
   output logic [clog2w(COL_TICKS)-1:0]   timer_nxt,
   output logic [clog2w(COLS)-1:0]        col_nxt,
   output logic                           boundary,
   output logic                           frame_tick
);

   localparam int unsigned TW = clog2w(COL_TICKS);
   localparam int unsigned CW = clog2w(COLS);

   logic [TW-1:0] timer;
   logic [CW-1:0] col;
   logic          last_tick;
   logic          last_col;

   always_comb begin
      last_tick = (timer == TW'(COL_TICKS - 1));
      last_col  = (col == CW'(COLS - 1));
      boundary  = last_tick && last_col;
      timer_nxt = last_tick ? '0 : timer + TW'(1);
      col_nxt   = col;
      if (last_tick) begin
         col_nxt = last_col ? '0 : col + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer      <= '0;
         col        <= '0;
         frame_tick <= 1'b0;
      end else begin
         timer      <= timer_nxt;
         col        <= col_nxt;
         frame_tick <= boundary;
      end
   end

endmodule

// File: rtl/led_matrix_pwm.sv
// Time-multiplexed active-low LED matrix driver with frame shadowing and blanking.
// Define LED_MATRIX_PWM_DIM_EN to build the brightness shadow and per-column PWM.
module led_matrix_pwm
   import led_matrix_pkg::*;
#(
   parameter int unsigned ROWS        = 8,
   parameter int unsigned COLS        = 4,
   parameter int unsigned COL_TICKS   = 50_000,
   parameter int unsigned BLANK_TICKS = 0,
   parameter int unsigned PWM_BITS    = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ROWS*COLS-1:0]     data,
   input  logic [PWM_BITS-1:0]      brightness,
   output logic                     frame_tick,
   output logic [ROWS-1:0]          rows,
   output logic [COLS-1:0]          cols
);

   localparam int unsigned TW = clog2w(COL_TICKS);
   localparam int unsigned CW = clog2w(COLS);
   localparam int unsigned SW = clog2w(ROWS * COLS);

   logic [TW-1:0]        timer_nxt;
   logic [CW-1:0]        col_nxt;
   logic                 boundary;
   logic [ROWS*COLS-1:0] shadow;
   logic [ROWS*COLS-1:0] shadow_nxt;
   logic                 loaded;
   logic                 loaded_nxt;
   logic                 active;
   logic                 duty_on;
   slot_phase_e          phase;
   logic [SW-1:0]        msb;
   logic [ROWS-1:0]      rows_d;
   logic [COLS-1:0]      cols_d;

   led_matrix_scan #(
      .COLS      (COLS),
      .COL_TICKS (COL_TICKS)
   ) u_scan (
      .clk        (clk),
      .rst        (rst),
      .timer_nxt  (timer_nxt),
      .col_nxt    (col_nxt),
      .boundary   (boundary),
      .frame_tick (frame_tick)
   );

   // Outputs are registered from next-state values so column 0 of a new
   // frame lands in the same cycle as frame_tick.
   always_comb begin
      shadow_nxt = boundary ? data : shadow;
      loaded_nxt = loaded || boundary;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow <= '0;
         loaded <= 1'b0;
      end else begin
         shadow <= shadow_nxt;
         loaded <= loaded_nxt;
      end
   end

   if (BLANK_TICKS > 0) begin : g_blank
      assign active = (timer_nxt >= TW'(BLANK_TICKS));
   end else begin : g_noblank
      assign active = 1'b1;
   end

`ifdef LED_MATRIX_PWM_DIM_EN
   localparam int unsigned MW   = TW + 1;
   localparam int unsigned STEP = (COL_TICKS - BLANK_TICKS) >> PWM_BITS;

   logic [PWM_BITS-1:0] bright_shadow;
   logic [PWM_BITS-1:0] bright_nxt;
   logic [MW-1:0]       pwm_pos;
   logic [MW-1:0]       pwm_thr;

   always_comb begin
      bright_nxt = boundary ? brightness : bright_shadow;
      pwm_pos    = MW'(timer_nxt) - MW'(BLANK_TICKS);
      pwm_thr    = MW'(bright_nxt) * MW'(STEP);
      duty_on    = (|bright_nxt) && ((&bright_nxt) || (pwm_pos < pwm_thr));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bright_shadow <= '0;
      end else begin
         bright_shadow <= bright_nxt;
      end
   end
`else
   logic unused_brightness;
   assign unused_brightness = ^brightness;
   assign duty_on = 1'b1;
`endif

   always_comb begin
      if (!active) begin
         phase = PH_BLANK;
      end else if (loaded_nxt && duty_on) begin
         phase = PH_ON;
      end else begin
         phase = PH_OFF;
      end
   end

   always_comb begin
      rows_d = '1;
      cols_d = '1;
      msb    = SW'(slice_msb(32'(col_nxt), ROWS, COLS));
      case (phase)
         PH_ON: begin
            cols_d = COLS'(col_onecold(32'(col_nxt)));
            rows_d = ~shadow_nxt[msb -: ROWS];
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rows <= '1;
         cols <= '1;
      end else begin
         rows <= rows_d;
         cols <= cols_d;
      end
   end

endmodule

// File: tb/tb_led_matrix_pwm.sv
// Randomized self-checking bench for led_matrix_pwm, two instances (BLANK_TICKS 0 and 2).
module tb_led_matrix_pwm;

   localparam int unsigned CT     = 16;
   localparam int unsigned NC     = 4;
   localparam int unsigned NR     = 8;
   localparam int unsigned PB     = 2;
   localparam int unsigned PERIOD = CT * NC;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] data;
   logic [1:0]  brightness;
   logic        ft_a, ft_b;
   logic [7:0]  rows_a, rows_b;
   logic [3:0]  cols_a, cols_b;

   int unsigned n;
   logic [31:0] m_shadow;
   logic [1:0]  m_bright;
   bit          m_loaded;
   bit          rand_data;
   int          n_checks;
   int          n_fail;

   always #5 clk = ~clk;

   led_matrix_pwm #(
      .ROWS(NR), .COLS(NC), .COL_TICKS(CT), .BLANK_TICKS(0), .PWM_BITS(PB)
   ) dut_a (
      .clk(clk), .rst(rst), .data(data), .brightness(brightness),
      .frame_tick(ft_a), .rows(rows_a), .cols(cols_a)
   );

   led_matrix_pwm #(
      .ROWS(NR), .COLS(NC), .COL_TICKS(CT), .BLANK_TICKS(2), .PWM_BITS(PB)
   ) dut_b (
      .clk(clk), .rst(rst), .data(data), .brightness(brightness),
      .frame_tick(ft_b), .rows(rows_b), .cols(cols_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, n, obs, exp);
      end
   endtask

   // Expected {frame_tick, cols, rows} after clock cycle cyc since reset release.
   function automatic logic [12:0] model_out(input int unsigned cyc, input int unsigned blank);
      int unsigned t, c, step;
      bit          lit;
      logic [7:0]  r;
      logic [3:0]  k;
      logic [3:0]  one;
      t    = cyc % CT;
      c    = (cyc / CT) % NC;
      step = (CT - blank) >> PB;
      lit  = m_loaded && (t >= blank);
`ifdef LED_MATRIX_PWM_DIM_EN
      if (lit) begin
         lit = (m_bright != 2'd0) &&
               ((m_bright == 2'd3) || ((t - blank) < (int'(m_bright) * step)));
      end
`endif
      r = 8'hFF;
      k = 4'hF;
      if (lit) begin
         one = 4'b0001 << c;
         k   = ~one;
         r   = ~m_shadow[(NC - 1 - c) * NR +: NR];
      end
      return {(cyc != 0) && (cyc % PERIOD == 0), k, r};
   endfunction

   task automatic step_cycle();
      logic [12:0] ea, eb;
      @(posedge clk);
      n++;
      if (n % PERIOD == 0) begin
         m_shadow = data;
         m_bright = brightness;
         m_loaded = 1'b1;
      end
      #1;
      ea = model_out(n, 0);
      eb = model_out(n, 2);
      check("a_frame_tick", 32'(ft_a),   32'(ea[12]));
      check("a_cols",       32'(cols_a), 32'(ea[11:8]));
      check("a_rows",       32'(rows_a), 32'(ea[7:0]));
      check("b_frame_tick", 32'(ft_b),   32'(eb[12]));
      check("b_cols",       32'(cols_b), 32'(eb[11:8]));
      check("b_rows",       32'(rows_b), 32'(eb[7:0]));
      @(negedge clk);
      if (rand_data) data = $urandom;
   endtask

   task automatic run(input int unsigned k);
      repeat (k) step_cycle();
   endtask

   task automatic run_to(input int unsigned pos);
      for (int i = 0; i < int'(PERIOD) && (n % PERIOD) != pos; i++) step_cycle();
   endtask

   task automatic check_dark(input string tag);
      check({tag, "_a_frame_tick"}, 32'(ft_a),   32'h0);
      check({tag, "_a_cols"},       32'(cols_a), 32'hF);
      check({tag, "_a_rows"},       32'(rows_a), 32'hFF);
      check({tag, "_b_frame_tick"}, 32'(ft_b),   32'h0);
      check({tag, "_b_cols"},       32'(cols_b), 32'hF);
      check({tag, "_b_rows"},       32'(rows_b), 32'hFF);
   endtask

   // Asserts reset off-edge and checks that outputs go dark without a clock.
   task automatic do_reset(input int unsigned hold);
      #2;
      rst = 1'b1;
      #1;
      check_dark("rst_async");
      repeat (hold) @(negedge clk);
      check_dark("rst_hold");
      rst      = 1'b0;
      n        = 0;
      m_loaded = 1'b0;
      m_shadow = '0;
      m_bright = '0;
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog cycle=%0d observed=timeout expected=finish", n);
      $fatal(1, "bench timeout");
   end

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      n          = 0;
      rand_data  = 1'b0;
      data       = 32'hFFFF_FFFF;
      brightness = 2'd3;
      @(negedge clk);
      do_reset(3);

      run(70);

      data = 32'h8142_2418;
      run(2 * PERIOD);

      brightness = 2'd1;
      run(2 * PERIOD);
      brightness = 2'd0;
      run(2 * PERIOD);

      brightness = 2'd3;
      data       = 32'h0;
      run_to(1);
      run_to(19);
      data = 32'hFFFF_FFFF;
      run(PERIOD + 20);

      rand_data = 1'b1;
      repeat (25) begin
         brightness = 2'($urandom_range(0, 3));
         run(CT);
      end
      rand_data = 1'b0;

      brightness = 2'd3;
      data       = 32'hA5C3_0FF0;
      run_to(37);
      do_reset(2);
      run(PERIOD + 20);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/led_matrix_pwm.md
# led_matrix_pwm

Parametrised time-multiplexed LED matrix driver for ROWS x COLS active-low matrices. It scans one column at a time and takes a frame of pixel data plus a global brightness value at each frame boundary, so frames never tear. Per-column PWM dimming and anti-ghost blanking are built in. It sits between the application logic that produces frame data and the board's row/column pins.

## Interface
- ROWS, 8, LEDs per column (row lines)
- COLS, 4, scanned columns
- COL_TICKS, 50_000, clocks per column slot; must be at least BLANK_TICKS + 2**PWM_BITS
- BLANK_TICKS, 0, clocks at the start of each slot with all lines off
- PWM_BITS, 4, brightness resolution
- clk  in  1  system clock (12 MHz on board)
- rst  in  1  reset, asynchronous, active-high
- data  in  ROWS*COLS  frame pixels, '1' = on; column c uses bits [(COLS-c)*ROWS-1 -: ROWS]; row r within that slice is bit r
- brightness  in  PWM_BITS  global brightness; 0 = dark, all-ones = full
- frame_tick  out  1  one-clock pulse per frame, when shadow data is loaded
- rows  out  ROWS  row lines, active low
- cols  out  COLS  column lines, active low

## Operation
- timer counts 0..COL_TICKS-1 and wraps. col counts 0..COLS-1 and advances when timer wraps, wrapping from COLS-1 to 0.
- Frame boundary: the edge where timer==COL_TICKS-1 and col==COLS-1.
  - At that edge, data is copied into a shadow register, and brightness into a brightness shadow.
  - frame_tick is 1 for the following cycle only.
- data and brightness changes between boundaries have no visible effect until the next boundary.
- Active window: BLANK_TICKS <= timer <= COL_TICKS-1.
  - localparam STEP = (COL_TICKS-BLANK_TICKS) >> PWM_BITS.
- lit is true when all of the following hold:
  - timer is in the active window;
  - brightness shadow != 0;
  - brightness shadow is all-ones, or timer-BLANK_TICKS < brightness_shadow*STEP.
  - The multiply uses width clog2(COL_TICKS)+1; it must not overflow.
- Output rules:
  - When lit: cols = ~(1<<col) and rows = ~shadow column slice.
  - When not lit: rows and cols are all ones. A row line is never low while its column is deselected.
- Reset values: timer=0, col=0, shadow=0, brightness shadow=0, frame_tick=0, rows='1, cols='1.
  - The display stays dark until the first frame boundary, COLS*COL_TICKS clocks after reset release.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously). Scanning restarts at col 0 when reset is released.

## Timing
- rows, cols and frame_tick are registered, with one clock of latency from the timer/col state that drives them.
- The first column-0 output of a new frame appears in the same cycle that frame_tick is high.
- Frame period: COLS*COL_TICKS clocks exactly. Column slot: COL_TICKS clocks exactly.
- With full brightness and BLANK_TICKS=0, the column outputs never go dark between columns: cols changes directly from one one-cold value to the next.

## Configuration
- LED_MATRIX_PWM_DIM_EN defined: brightness shadow and PWM comparison are compiled in, as described above.
- LED_MATRIX_PWM_DIM_EN undefined:
  - The brightness port is present but ignored, and no brightness shadow is built.
  - lit = timer is in the active window. Blanking still applies.

## Structure
- Package led_matrix_pkg holds:
  - the timer width function (clog2);
  - a one-cold column select function;
  - the data slice helper for column c.
- Sub-module led_matrix_scan holds timer, col, frame boundary detection and the frame_tick register.
- The top level holds the shadow registers, PWM compare and output registers.

## Test plan
Common parameters unless stated: ROWS=8, COLS=4, COL_TICKS=16, BLANK_TICKS=0, PWM_BITS=2 (STEP=4).
1. Reset. Hold rst for 3 clocks, then release with data=32'hFFFFFFFF, brightness=3 -> rows=8'hFF, cols=4'hF, frame_tick=0 for 64 clocks. frame_tick pulses at clock 64. Then cols=4'b1110, rows=8'h00.
2. data=32'h81422418, brightness=3 -> in frame 2, the col0..3 slots show rows 8'h7E, 8'hBD, 8'hDB, 8'hE7 with cols 1110, 1101, 1011, 0111. Each slot is 16 clocks.
3. brightness=1 -> each column is lit for 4 clocks, then rows/cols are all ones for 12 clocks. brightness=0 -> dark for the whole frame. frame_tick keeps a period of 64 clocks.
4. data changes from 32'h0 to 32'hFFFFFFFF at clock 20 of a frame -> no row goes low until the next frame_tick.
5. BLANK_TICKS=2, brightness=3 -> each slot has 2 dark clocks, then 14 lit clocks. With brightness=1 (STEP=3), each slot has 2 dark clocks, 3 lit clocks and 11 dark clocks.
6. Assert rst during col 2 -> rows=8'hFF, cols=4'hF in the same cycle. After release, the display stays dark for 64 clocks and frame_tick pulses at clock 64.
